// File: rtl/output_buffer_pkg.sv
// Shared layer codes, per-layer block counts / half-widths and buffer state type
// for the LeNet write-back stage (output_buffer and ob_pack).
// Layer codes stand in for the SCONV_*/SFC_* values of the shared layer header.
package output_buffer_pkg;

  localparam int LANE_W    = 16;
  localparam int OUT_LANES = 70;
  localparam int OUT_W     = OUT_LANES * LANE_W;

  localparam logic [3:0] SCONV_1 = 4'd1;
  localparam logic [3:0] SCONV_2 = 4'd2;
  localparam logic [3:0] SFC_1   = 4'd3;
  localparam logic [3:0] SFC_2   = 4'd4;

  // Blocks written per layer: SCONV_1 is 6 channels x 7 row groups.
  localparam int SCONV_1_BLOCKS = 42;
  localparam int SCONV_2_BLOCKS = 16;
  localparam int SFC_1_BLOCKS   = 1;
  localparam int SFC_2_BLOCKS   = 1;

  // Lanes per memory word for each layer (same split as the input side).
  localparam int SCONV_1_HALF = 56;
  localparam int SCONV_2_HALF = 50;
  localparam int SFC_1_HALF   = 60;
  localparam int SFC_2_HALF   = 42;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  function automatic logic layer_valid(input logic [3:0] layer);
    return (layer == SCONV_1) || (layer == SCONV_2) ||
           (layer == SFC_1)   || (layer == SFC_2);
  endfunction

  // Unknown layer codes give 0 so nothing is packed.
  function automatic int layer_half(input logic [3:0] layer);
    case (layer)
      SCONV_1: return SCONV_1_HALF;
      SCONV_2: return SCONV_2_HALF;
      SFC_1:   return SFC_1_HALF;
      SFC_2:   return SFC_2_HALF;
      default: return 0;
    endcase
  endfunction

  // Unknown layer codes give 1 so the wrap compare never underflows.
  function automatic int layer_blocks(input logic [3:0] layer);
    case (layer)
      SCONV_1: return SCONV_1_BLOCKS;
      SCONV_2: return SCONV_2_BLOCKS;
      SFC_1:   return SFC_1_BLOCKS;
      SFC_2:   return SFC_2_BLOCKS;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/output_buffer_ob_pack.sv
// ob_pack: combinational split of one result block into the two 70-lane memory
// words; lanes [0,H) -> out_2, lanes [H,2H) -> out_1, everything else 0.
// OUTPUT_BUFFER_RELU_EN defined: negative used lanes are forced to 0 (ReLU).
module ob_pack
  import output_buffer_pkg::*;
#(
  parameter int MAC_NUM = 120
) (
  input  logic [3:0]             cur_state,
  input  logic [MAC_NUM*16-1:0]  res_in,
  output logic [OUT_W-1:0]       out_1,
  output logic [OUT_W-1:0]       out_2
);

  int half;

  function automatic logic [LANE_W-1:0] act(input logic [LANE_W-1:0] v);
`ifdef OUTPUT_BUFFER_RELU_EN
    return v[LANE_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Route each output lane from its source lane for the current layer.
  always_comb begin
    out_1 = '0;
    out_2 = '0;
    half  = layer_half(cur_state);
    for (int i = 0; i < OUT_LANES; i++) begin
      if (i < half) begin
        out_2[i*LANE_W +: LANE_W] = act(res_in[i*LANE_W +: LANE_W]);
        out_1[i*LANE_W +: LANE_W] = act(res_in[(i+half)*LANE_W +: LANE_W]);
      end
    end
  end

endmodule

// File: rtl/output_buffer.sv
// output_buffer: single-entry write-back register with valid/ready capture,
// held write request, per-layer block addressing and end-of-layer done pulse.
// Capture at edge N -> wr_en in cycle N+1; ReLU via OUTPUT_BUFFER_RELU_EN.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int MAC_NUM = 120,
  parameter int ADDR_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cur_state,
  input  logic                  res_valid,
  input  logic [MAC_NUM*16-1:0] res_in,
  output logic                  res_ready,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [OUT_W-1:0]      out_1,
  output logic [OUT_W-1:0]      out_2,
  output logic                  done
);

  buf_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [OUT_W-1:0]    out_1_q, out_1_d;
  logic [OUT_W-1:0]    out_2_q, out_2_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic [3:0]          cur_state_q;

  logic [OUT_W-1:0]    pack_1, pack_2;
  logic                cap, wr_acc;
  logic [ADDR_W-1:0]   blk_base, blk_last;

  ob_pack #(.MAC_NUM(MAC_NUM)) u_pack (
    .cur_state (cur_state),
    .res_in    (res_in),
    .out_1     (pack_1),
    .out_2     (pack_2)
  );

  assign wr_en   = (state_q == ST_FULL);
  assign wr_addr = wr_addr_q;
  assign out_1   = out_1_q;
  assign out_2   = out_2_q;
  assign done    = done_q;

  // Handshake: accept a block when the entry is empty or draining this cycle.
  always_comb begin
    res_ready = layer_valid(cur_state) && ((state_q == ST_EMPTY) || wr_ready);
    cap       = res_valid && res_ready;
    wr_acc    = (state_q == ST_FULL) && wr_ready;
  end

  // Next state: capture/drain of the entry, block counter with layer-change restart.
  always_comb begin
    blk_base  = (cur_state != cur_state_q) ? '0 : blk_cnt_q;
    blk_last  = ADDR_W'(layer_blocks(cur_state) - 1);
    state_d   = state_q;
    blk_cnt_d = blk_base;
    wr_addr_d = wr_addr_q;
    out_1_d   = out_1_q;
    out_2_d   = out_2_q;
    last_d    = last_q;
    done_d    = wr_acc && last_q;
    if (cap) begin
      state_d   = ST_FULL;
      wr_addr_d = blk_base;
      out_1_d   = pack_1;
      out_2_d   = pack_2;
      last_d    = (blk_base == blk_last);
      blk_cnt_d = (blk_base == blk_last) ? '0 : blk_base + 1'b1;
    end else if (wr_acc) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers; reset drops any held entry without writing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      blk_cnt_q   <= '0;
      wr_addr_q   <= '0;
      out_1_q     <= '0;
      out_2_q     <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_state_q <= cur_state;
    end else begin
      state_q     <= state_d;
      blk_cnt_q   <= blk_cnt_d;
      wr_addr_q   <= wr_addr_d;
      out_1_q     <= out_1_d;
      out_2_q     <= out_2_d;
      last_q      <= last_d;
      done_q      <= done_d;
      cur_state_q <= cur_state;
    end
  end

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: reset, packing, backpressure, wrap/done,
// ReLU build option, reset while stalled, and a layer switch.
module tb_output_buffer;
  import output_buffer_pkg::*;

  localparam int MAC = 120;
  localparam int AW  = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          cur_state;
  logic                res_valid;
  logic [MAC*16-1:0]   res_in;
  logic                res_ready;
  logic                wr_en;
  logic                wr_ready;
  logic [AW-1:0]       wr_addr;
  logic [OUT_W-1:0]    out_1;
  logic [OUT_W-1:0]    out_2;
  logic                done;

  int checks   = 0;
  int failures = 0;

  output_buffer #(.MAC_NUM(MAC), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cur_state (cur_state),
    .res_valid (res_valid),
    .res_in    (res_in),
    .res_ready (res_ready),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .out_1     (out_1),
    .out_2     (out_2),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane(input logic [OUT_W-1:0] w, input int i);
    return w[i*16 +: 16];
  endfunction

  // Block with lane k = base + k.
  function automatic logic [MAC*16-1:0] ramp(input int base);
    logic [MAC*16-1:0] b;
    for (int k = 0; k < MAC; k++) b[k*16 +: 16] = 16'(base + k);
    return b;
  endfunction

  // Check both words against a half-width split of a ramp block.
  task automatic check_split(input string tag, input int base, input int h);
    for (int i = 0; i < OUT_LANES; i++) begin
      check($sformatf("%s_o2_l%0d", tag, i), 32'(lane(out_2, i)), (i < h) ? 32'(16'(base + i)) : 32'd0);
      check($sformatf("%s_o1_l%0d", tag, i), 32'(lane(out_1, i)), (i < h) ? 32'(16'(base + h + i)) : 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    res_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_l3;
    rst = 1'b1; cur_state = SCONV_1; res_valid = 1'b0; res_in = '0; wr_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_out1_zero", 32'(out_1 == '0), 32'd1);
    check("rst_out2_zero", 32'(out_2 == '0), 32'd1);
    #1 check("rst_res_ready", 32'(res_ready), 32'd1);

    // SCONV_1 packing, lane k = k
    res_in = ramp(0); res_valid = 1'b1;
    #1 check("c1_res_ready", 32'(res_ready), 32'd1);
    tick();
    res_valid = 1'b0;
    check("c1_wr_en", 32'(wr_en), 32'd1);
    check("c1_addr", 32'(wr_addr), 32'd0);
    check_split("c1", 0, 56);
    tick();
    check("c1_drain", 32'(wr_en), 32'd0);

    // Backpressure: two blocks, wr_ready low 3 cycles
    do_reset();
    wr_ready = 1'b0;
    res_in = ramp(1000); res_valid = 1'b1;
    #1 check("bp_a_ready", 32'(res_ready), 32'd1);
    tick();
    res_in = ramp(2000);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_b_ready%0d", c), 32'(res_ready), 32'd0);
      check($sformatf("bp_wr_en%0d", c), 32'(wr_en), 32'd1);
      check($sformatf("bp_addr%0d", c), 32'(wr_addr), 32'd0);
      check($sformatf("bp_o2_%0d", c), 32'(lane(out_2, 0)), 32'd1000);
      check($sformatf("bp_o1_%0d", c), 32'(lane(out_1, 55)), 32'd1111);
      tick();
    end
    wr_ready = 1'b1;
    #1 check("bp_b_ready_go", 32'(res_ready), 32'd1);
    tick();
    res_valid = 1'b0;
    check("bp_b_wr_en", 32'(wr_en), 32'd1);
    check("bp_b_addr", 32'(wr_addr), 32'd1);
    check("bp_b_o2", 32'(lane(out_2, 0)), 32'd2000);
    tick();
    check("bp_drain", 32'(wr_en), 32'd0);
    check("bp_done", 32'(done), 32'd0);

    // SCONV_2: 16 back-to-back blocks, done once, wrap to 0
    cur_state = SCONV_2; res_valid = 1'b1;
    for (int b = 0; b < 16; b++) begin
      res_in = ramp(b * 100);
      tick();
      check($sformatf("c2_addr%0d", b), 32'(wr_addr), 32'(b));
      check($sformatf("c2_done%0d", b), 32'(done), 32'd0);
    end
    check_split("c2_last", 1500, 50);
    res_in = ramp(7);
    tick();
    res_valid = 1'b0;
    check("c2_done_pulse", 32'(done), 32'd1);
    check("c2_wrap_addr", 32'(wr_addr), 32'd0);
    check("c2_wrap_wr_en", 32'(wr_en), 32'd1);
    tick();
    check("c2_done_once", 32'(done), 32'd0);
    check("c2_idle", 32'(wr_en), 32'd0);

    // ReLU in SFC_2
    cur_state = SFC_2;
    res_in = '0;
    res_in[3*16 +: 16] = 16'hFFF0;
    res_in[4*16 +: 16] = 16'h0010;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
`ifdef OUTPUT_BUFFER_RELU_EN
    exp_l3 = 16'h0000;
`else
    exp_l3 = 16'hFFF0;
`endif
    check("relu_l3", 32'(lane(out_2, 3)), 32'(exp_l3));
    check("relu_l4", 32'(lane(out_2, 4)), 32'h0010);
    check("relu_addr", 32'(wr_addr), 32'd0);
    tick();
    check("relu_done", 32'(done), 32'd1);

    // Reset while FULL and stalled
    cur_state = SCONV_1; wr_ready = 1'b0;
    res_in = ramp(0); res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("rs_full", 32'(wr_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_wr_en", 32'(wr_en), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    check("rs_addr", 32'(wr_addr), 32'd0);
    tick();
    check("rs_done2", 32'(done), 32'd0);
    wr_ready = 1'b1; res_valid = 1'b1;
    tick();
    check("rs_first_addr", 32'(wr_addr), 32'd0);

    // Layer switch SCONV_1 -> SFC_1 after 5 blocks (0 done above, 1..4 here)
    for (int b = 1; b < 5; b++) begin
      tick();
      check($sformatf("ls_addr%0d", b), 32'(wr_addr), 32'(b));
    end
    cur_state = SFC_1; res_in = ramp(300);
    tick();
    res_valid = 1'b0;
    check("ls_fc1_addr", 32'(wr_addr), 32'd0);
    check("ls_fc1_done_before", 32'(done), 32'd0);
    check_split("ls_fc1", 300, 60);
    tick();
    check("ls_fc1_done", 32'(done), 32'd1);
    tick();
    check("ls_fc1_done_end", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
